// File: rtl/ccff_chain_loader.sv
// Streams host words MSB-first into the serial configuration-flip-flop chain, counts
// CHAIN_LEN bits, and optionally recirculates the chain once to CRC-check its contents.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_en,
  output logic              busy,
  output logic              done,
  output logic              crc_err,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam int              NB_W     = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_VERIFY,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [NB_W-1:0]   bits_left_q, bits_left_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]        crc_in_q, crc_in_d;
  logic [7:0]        crc_out_q, crc_out_d;
  logic              verify_q, verify_d;
  logic              word_ready_q, word_ready_d;
  logic              chain_en_q, chain_en_d;
  logic              head_q, head_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              crc_err_q, crc_err_d;

  logic [CNT_W-1:0]  cnt_inc;
  logic [NB_W-1:0]   nbits;
  int                remain;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  always_comb begin
    // NOTE: every _d starts from its _q, so no branch can leave a latch behind.
    state_d      = state_q;
    shreg_d      = shreg_q;
    bits_left_d  = bits_left_q;
    bit_cnt_d    = bit_cnt_q;
    crc_in_d     = crc_in_q;
    crc_out_d    = crc_out_q;
    verify_d     = verify_q;
    word_ready_d = word_ready_q;
    chain_en_d   = chain_en_q;
    head_d       = head_q;
    busy_d       = busy_q;
    done_d       = done_q;
    crc_err_d    = crc_err_q;

    cnt_inc = bit_cnt_q + CNT_W'(1);
    remain  = CHAIN_LEN - int'(bit_cnt_q);
    nbits   = (remain >= WORD_W) ? NB_W'(WORD_W) : NB_W'(remain);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          bit_cnt_d    = '0;
          crc_in_d     = '0;
          crc_out_d    = '0;
          crc_err_d    = 1'b0;
          verify_d     = verify;
          word_ready_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (word_valid && word_ready_q) begin
          head_d       = word_in[WORD_W-1];
          shreg_d      = word_in << 1;
          bits_left_d  = nbits;
          word_ready_d = 1'b0;
          chain_en_d   = 1'b1;
          state_d      = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        bit_cnt_d = cnt_inc;
        crc_in_d  = crc8_step(crc_in_q, head_q);
        if (bits_left_q == NB_W'(1)) begin
          if (cnt_inc == LAST_CNT) begin
            if (verify_q) begin
              bit_cnt_d = '0;
              state_d   = ST_VERIFY;
            end else begin
              chain_en_d = 1'b0;
              busy_d     = 1'b0;
              done_d     = 1'b1;
              crc_err_d  = 1'b0;
              state_d    = ST_DONE;
            end
          end else begin
            chain_en_d   = 1'b0;
            word_ready_d = 1'b1;
            state_d      = ST_LOAD;
          end
        end else begin
          head_d      = shreg_q[WORD_W-1];
          shreg_d     = shreg_q << 1;
          bits_left_d = bits_left_q - NB_W'(1);
        end
      end

      ST_VERIFY: begin
        // The chain is recirculating, so the tail carries the loaded bits in load order.
        bit_cnt_d = cnt_inc;
        crc_out_d = crc8_step(crc_out_q, ccff_tail);
        if (cnt_inc == LAST_CNT) begin
          chain_en_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          crc_err_d  = (crc_out_d != crc_in_q);
          state_d    = ST_DONE;
        end
      end

      ST_DONE: begin
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    // NOTE: state updates use non-blocking assignments; the reset is sampled on the clock.
    if (!pReset_n) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bits_left_q  <= '0;
      bit_cnt_q    <= '0;
      crc_in_q     <= '0;
      crc_out_q    <= '0;
      verify_q     <= 1'b0;
      word_ready_q <= 1'b0;
      chain_en_q   <= 1'b0;
      head_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      crc_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bits_left_q  <= bits_left_d;
      bit_cnt_q    <= bit_cnt_d;
      crc_in_q     <= crc_in_d;
      crc_out_q    <= crc_out_d;
      verify_q     <= verify_d;
      word_ready_q <= word_ready_d;
      chain_en_q   <= chain_en_d;
      head_q       <= head_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      crc_err_q    <= crc_err_d;
    end
  end

  assign ccff_head  = (state_q == ST_VERIFY) ? ccff_tail : head_q;
  assign word_ready = word_ready_q;
  assign chain_en   = chain_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign crc_err    = crc_err_q;
  assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a 5-bit/4-bit-word instance with a chain model,
// and a 16-bit/8-bit-word instance for the exact-multiple case.
module tb_ccff_chain_loader;

  logic clk;
  logic rst_n;

  // Instance A: CHAIN_LEN=5, WORD_W=4
  logic       a_start, a_verify, a_valid, a_ready, a_head, a_tail, a_en;
  logic       a_busy, a_done, a_err, a_stuck;
  logic [3:0] a_word;
  logic [2:0] a_cnt;
  logic [4:0] a_chain;

  // Instance B: CHAIN_LEN=16, WORD_W=8
  logic        b_start, b_verify, b_valid, b_ready, b_head, b_tail, b_en;
  logic        b_busy, b_done, b_err;
  logic [7:0]  b_word;
  logic [4:0]  b_cnt;
  logic [15:0] b_chain;

  int checks   = 0;
  int failures = 0;
  int a_cyc, a_en_cyc, a_done_cyc;
  logic       a_err_at_done;
  logic [2:0] a_cnt_at_done;

  ccff_chain_loader #(.CHAIN_LEN(5), .WORD_W(4)) dut_a (
    .prog_clk(clk), .pReset_n(rst_n), .start(a_start), .verify(a_verify),
    .word_in(a_word), .word_valid(a_valid), .word_ready(a_ready),
    .ccff_head(a_head), .ccff_tail(a_tail), .chain_en(a_en), .busy(a_busy),
    .done(a_done), .crc_err(a_err), .bit_cnt(a_cnt)
  );

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut_b (
    .prog_clk(clk), .pReset_n(rst_n), .start(b_start), .verify(b_verify),
    .word_in(b_word), .word_valid(b_valid), .word_ready(b_ready),
    .ccff_head(b_head), .ccff_tail(b_tail), .chain_en(b_en), .busy(b_busy),
    .done(b_done), .crc_err(b_err), .bit_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain models: first bit loaded ends up at the tail end.
  always @(posedge clk) if (a_en) a_chain <= {a_chain[3:0], a_head};
  always @(posedge clk) if (b_en) b_chain <= {b_chain[14:0], b_head};
  assign a_tail = a_stuck ? 1'b0 : a_chain[4];
  assign b_tail = b_chain[15];

  typedef struct {
    logic       start;
    logic       vfy;
    logic       valid;
    logic [3:0] word;
    logic [8:0] exp;  // {ready, en, head(masked by en), busy, done, crc_err, cnt[2:0]}
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] a_outs();
    return {a_ready, a_en, a_en ? a_head : 1'b0, a_busy, a_done, a_err, a_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    a_cyc++;
    if (a_en) a_en_cyc++;
  endtask

  task automatic a_start_run(input logic vfy);
    a_start  = 1'b1;
    a_verify = vfy;
    tick();
    a_start  = 1'b0;
    a_verify = 1'b0;
    a_cyc    = 1;
    a_en_cyc = 0;
  endtask

  task automatic a_wait_ready(input string name);
    int guard = 0;
    while (!a_ready && guard < 50) begin
      tick();
      guard++;
    end
    check(name, a_ready, 1);
  endtask

  task automatic a_send(input logic [3:0] w);
    a_valid = 1'b1;
    a_word  = w;
    tick();
    a_valid = 1'b0;
    a_word  = 4'h0;
  endtask

  task automatic a_wait_done(input string name);
    int guard = 0;
    while (!a_done && guard < 100) begin
      tick();
      guard++;
    end
    check(name, a_done, 1);
    a_done_cyc    = a_cyc;
    a_err_at_done = a_err;
    a_cnt_at_done = a_cnt;
  endtask

  task automatic a_finish_run(input logic [3:0] w0, input logic [3:0] w1, input int stall);
    logic [2:0] cnt0;
    int bad = 0;
    a_wait_ready("ready_w0");
    a_send(w0);
    a_wait_ready("ready_w1");
    cnt0 = a_cnt;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (a_en || a_cnt != cnt0) bad++;
    end
    if (stall > 0) check("stall_hold", bad, 0);
    a_send(w1);
    a_wait_done("done_seen");
    tick();
    check("done_single_pulse", a_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, wr_cycles, dn;
    rst_n   = 1'b0;
    a_start = 0; a_verify = 0; a_valid = 0; a_word = 0; a_stuck = 0;
    b_start = 0; b_verify = 0; b_valid = 0; b_word = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", {a_ready, a_en, a_head, a_busy, a_done, a_err, a_cnt}, 0);
    check("reset_b", {b_ready, b_en, b_head, b_busy, b_done, b_err, b_cnt}, 0);
    rst_n = 1'b1;

    // Load 0xA then 0xF into a 5-bit chain, cycle by cycle.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 9'b1_0_0_1_0_0_000};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 4'hA, 9'b0_1_1_1_0_0_000};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 4'h0, 9'b0_1_0_1_0_0_001};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 4'h0, 9'b0_1_1_1_0_0_010};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 4'h0, 9'b0_1_0_1_0_0_011};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 4'h0, 9'b1_0_0_1_0_0_100};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 4'hF, 9'b0_1_1_1_0_0_100};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 4'h0, 9'b0_0_0_0_1_0_101};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 4'h0, 9'b0_0_0_0_0_0_101};
    for (int i = 0; i < 9; i++) begin
      a_start  = vecs[i].start;
      a_verify = vecs[i].vfy;
      a_valid  = vecs[i].valid;
      a_word   = vecs[i].word;
      tick();
      check($sformatf("vec%0d", i), a_outs(), vecs[i].exp);
    end
    a_start = 0; a_verify = 0; a_valid = 0; a_word = 0;
    check("load_chain", a_chain, 5'b10101);

    // Verify pass with an ideal chain.
    a_start_run(1'b1);
    a_finish_run(4'hA, 4'hF, 0);
    check("verify_done_cycle", a_done_cyc, 13);
    check("verify_en_cycles", a_en_cyc, 10);
    check("verify_crc_err", a_err_at_done, 0);
    check("verify_bit_cnt", a_cnt_at_done, 5);
    check("verify_chain", a_chain, 5'b10101);

    // Tail stuck at 0: CRC of 10101 (0x6B) differs from CRC of 00000.
    a_stuck = 1'b1;
    a_start_run(1'b1);
    a_finish_run(4'hA, 4'h8, 0);
    a_stuck = 1'b0;
    check("stuck_crc_err", a_err_at_done, 1);
    repeat (5) tick();
    check("crc_err_sticky", a_err, 1);
    a_start_run(1'b0);
    check("crc_err_cleared", a_err, 0);

    // 20-cycle stall between words.
    a_finish_run(4'hA, 4'hF, 20);
    check("stall_done_cycle", a_done_cyc, 28);
    check("stall_chain", a_chain, 5'b10101);
    check("stall_crc_err", a_err_at_done, 0);

    // Reset in the third SHIFT cycle.
    a_start_run(1'b0);
    a_wait_ready("rst_ready");
    a_send(4'hA);
    tick();
    tick();
    check("third_shift", {a_en, a_cnt}, {1'b1, 3'd2});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_reset", {a_ready, a_en, a_head, a_busy, a_done, a_err, a_cnt}, 0);
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_done) dn++;
    end
    check("no_done_after_reset", dn, 0);

    // Start while busy is ignored.
    a_start_run(1'b0);
    a_wait_ready("ign_ready");
    a_send(4'hA);
    tick();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("start_ignored", {a_busy, a_cnt}, {1'b1, 3'd2});
    a_wait_ready("ign_ready2");
    a_send(4'hF);
    a_wait_done("ign_done");
    check("ign_bit_cnt", a_cnt_at_done, 5);

    // Exact multiple: 16 bits from two 8-bit words, words always valid.
    b_start = 1'b1;
    b_valid = 1'b1;
    b_word  = 8'h3C;
    tick();
    b_start = 1'b0;
    n = 1;
    acc = 0;
    wr_cycles = 0;
    while (!b_done && n < 100) begin
      if (b_ready) begin
        acc++;
        wr_cycles++;
      end
      tick();
      n++;
      b_word = (acc == 0) ? 8'h3C : (acc == 1) ? 8'hC3 : 8'hFF;
    end
    b_valid = 1'b0;
    check("b_done_cycle", n, 19);
    check("b_words", acc, 2);
    check("b_done_seen", b_done, 1);
    check("b_bit_cnt", b_cnt, 16);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (b_ready) wr_cycles++;
    end
    check("b_ready_cycles", wr_cycles, 2);
    check("b_chain", b_chain, 16'h3CC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain controller that streams a bitstream from a host word interface into the FPGA's serial configuration-flip-flop chain (ccff_head → … → ccff_tail) of tiles such as connection and switch blocks. It serializes words MSB-first, gates chain shifting with an enable, and counts exactly CHAIN_LEN bits. It can then run an optional non-destructive verify pass: it recirculates the chain once and compares a CRC-8 of the bits read back against a CRC-8 of the bits loaded. It sits between the SoC/JTAG configuration port and the first tile's ccff_head, in the prog_clk domain.

## Interface
Parameters:
- CHAIN_LEN, 1024: total configuration bits in the chain (≥1).
- WORD_W, 8: host word width (≥1).
- CNT_W, $clog2(CHAIN_LEN+1): bit-counter width.

Ports:
- prog_clk  in  1  programming clock; all logic on rising edge.
- pReset_n  in  1  reset; synchronous and active-low.
- start  in  1  begin a load; sampled only in IDLE.
- verify  in  1  sampled with start; 1 = run the verify pass after the load.
- word_in  in  WORD_W  bitstream word; MSB is shifted first.
- word_valid  in  1  word_in valid.
- word_ready  out  1  controller accepts word_in this cycle.
- ccff_head  out  1  serial data to the chain head.
- ccff_tail  in  1  serial data from the chain tail.
- chain_en  out  1  chain shift enable (drives the chain clock gate); the chain captures ccff_head on an edge where chain_en=1.
- busy  out  1  high from the cycle after start until the done pulse.
- done  out  1  one-cycle pulse at end of the load or verify pass.
- crc_err  out  1  verify mismatch; sticky until the next accepted start.
- bit_cnt  out  CNT_W  bits shifted in the current pass.

## Operation
- States: IDLE, LOAD, SHIFT, VERIFY, DONE.
- IDLE:
  - On start=1, clear bit_cnt, crc_in, crc_out and crc_err, latch verify, then go to LOAD.
  - start is ignored in every other state.
- LOAD:
  - word_ready=1 and chain_en=0.
  - On word_valid&word_ready, capture word_in into the shift register, set nbits = min(WORD_W, CHAIN_LEN−bit_cnt), and go to SHIFT.
  - The chain holds while no word is offered; stalls are unbounded.
- SHIFT:
  - Each cycle: chain_en=1, ccff_head = shreg MSB (registered), shreg shifts left, bit_cnt+1.
  - Each cycle also updates crc_in with the shifted bit.
  - After nbits cycles: if bit_cnt==CHAIN_LEN, go to VERIFY when verify was latched, otherwise DONE. If not, go to LOAD.
  - The final word uses only its upper (CHAIN_LEN mod WORD_W) bits when the remainder is non-zero; the lower bits are discarded.
- VERIFY:
  - Runs for CHAIN_LEN cycles with chain_en=1 and ccff_head=ccff_tail (combinational recirculation), so chain contents are unchanged at exit.
  - Each cycle samples ccff_tail into crc_out. Bits emerge in the order they were loaded.
  - bit_cnt restarts at 0 and counts to CHAIN_LEN.
- DONE:
  - For one cycle: done=1, busy=0.
  - crc_err = (crc_out≠crc_in) if verify was latched, else 0.
  - Return to IDLE.
- CRC-8:
  - Polynomial 0x07, init 0x00, bit-serial.
  - fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00).
- word_valid outside LOAD is ignored; no word is consumed.

## Timing
- Reset values: word_ready=0, chain_en=0, ccff_head=0, busy=0, done=0, crc_err=0, bit_cnt=0; state IDLE.
- start at edge T → busy=1 and word_ready=1 in cycle T+1.
- Word accepted at edge A → chain_en=1 with ccff_head = word MSB in cycle A+1. The bits occupy cycles A+1..A+nbits.
- word_ready reasserts in cycle A+nbits+1, giving one bubble cycle per word.
- Load only, with words always valid: done asserts CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) + 1 cycles after start.
- The verify pass adds CHAIN_LEN cycles.
- chain_en is never 1 in IDLE, LOAD or DONE.
- Reset asserted mid-operation: next cycle all outputs take their reset values and chain_en=0. Chain contents are undefined and no done pulse is issued.
- CHAIN_LEN an exact multiple of WORD_W: the final word is fully used and the FSM goes straight to VERIFY/DONE with no extra LOAD.

## Test plan
- CHAIN_LEN=5, WORD_W=4, verify=0; words 0xA then 0xF → chain_en high for 4 cycles then 1; head sequence 1,0,1,0,1; chain model holds 10101; done pulses once; crc_err=0.
- Same configuration with verify=1 and an ideal chain model → 5 extra chain_en cycles; chain still 10101 afterwards; crc_err=0.
- verify=1 with the model's ccff_tail stuck at 0, load 0xA, 0x8 → crc_err=1 at done; crc_err stays 1 until the next start, then clears.
- word_valid low for 20 cycles between words → chain_en=0 and bit_cnt frozen during the gap; the final chain contents are unchanged versus the no-stall case.
- pReset_n low in the 3rd SHIFT cycle → next cycle busy=0, chain_en=0, bit_cnt=0. A start pulse while busy in a later run is ignored (bit_cnt is not cleared).
- CHAIN_LEN=16, WORD_W=8, words 0x3C, 0xC3 → exactly 2 words consumed, done 19 cycles after start, no third word_ready cycle.
